// File: rtl/axi_rb.sv
// axi_rb: single AXI read burst into a FIFO.
// Reads a burst length and a start address from two register ports, issues one
// INCR read burst, streams every returned beat into the FIFO under its back-pressure,
// then raises valid and stays in DONE until reset.
//
// state | meaning
// IDLE  | capture len/addr (one cycle)
// ADDR  | AR request held until arready
// DATA  | forward R beats into the FIFO, count them
// DONE  | transfer complete, terminal until reset
module axi_rb #(
    parameter logic [2:0] ARSIZE_VAL = 3'd2
) (
    input  logic        clk,
    input  logic        rst,

    output logic [31:0] arg_0_in_data,
    output logic        arg_0_write_valid,
    input  logic        arg_0_write_ready,
    output logic        arg_0_read_valid,
    input  logic [31:0] arg_0_out_data,
    input  logic        arg_0_read_ready,

    output logic [15:0] arg_3_s_axi_araddr,
    output logic [7:0]  arg_3_s_axi_arlen,
    output logic [1:0]  arg_3_s_axi_arburst,
    output logic [2:0]  arg_3_s_axi_arsize,
    output logic        arg_3_s_axi_arvalid,
    input  logic        arg_3_s_axi_arready,
    input  logic [31:0] arg_3_s_axi_rdata,
    input  logic        arg_3_s_axi_rvalid,
    output logic        arg_3_s_axi_rready,

    output logic [15:0] arg_3_s_axi_awaddr,
    output logic [1:0]  arg_3_s_axi_awburst,
    output logic [7:0]  arg_3_s_axi_awlen,
    output logic [2:0]  arg_3_s_axi_awsize,
    output logic        arg_3_s_axi_awvalid,
    input  logic        arg_3_s_axi_awready,
    output logic [31:0] arg_3_s_axi_wdata,
    output logic [3:0]  arg_3_s_axi_wstrb,
    output logic        arg_3_s_axi_wvalid,
    input  logic        arg_3_s_axi_wready,
    input  logic        arg_3_s_axi_bvalid,
    output logic        arg_3_s_axi_bready,

    output logic [7:0]  arg_1_raddr,
    input  logic [7:0]  arg_1_rdata,
    output logic [7:0]  arg_1_waddr,
    output logic [7:0]  arg_1_wdata,
    output logic        arg_1_wen,

    output logic [15:0] arg_2_raddr,
    input  logic [15:0] arg_2_rdata,
    output logic [15:0] arg_2_waddr,
    output logic [15:0] arg_2_wdata,
    output logic        arg_2_wen,

    output logic        valid
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t      state_q;
    logic [7:0]  len_q;
    logic [15:0] addr_q;
    logic [8:0]  cnt_q, cnt_d;
    logic        arvalid_q;
    logic        valid_q;
    logic        in_data;
    logic        beat;
    logic        unused_inputs;

    // Beat qualification: a word moves only while in DATA with both sides ready
    always_comb begin
        in_data = (state_q == S_DATA);
        beat    = in_data & arg_3_s_axi_rvalid & arg_0_write_ready;
        cnt_d   = beat ? cnt_q + 9'd1 : cnt_q;
    end

    // Sequencer: capture, address phase, data phase, terminal done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_q     <= 8'd0;
            addr_q    <= 16'd0;
            cnt_q     <= 9'd0;
            arvalid_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    len_q     <= arg_1_rdata;
                    addr_q    <= arg_2_rdata;
                    arvalid_q <= 1'b1;
                    state_q   <= S_ADDR;
                end
                S_ADDR: begin
                    if (arg_3_s_axi_arready) begin
                        arvalid_q <= 1'b0;
                        cnt_q     <= 9'd0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_d;
                    // Compare before increment so len 255 finishes at count 255, no wrap
                    if (beat && (cnt_q == {1'b0, len_q})) begin
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b1;
                end
            endcase
        end
    end

    // Output mapping: AR from registers, R-to-FIFO path combinational in DATA only
    always_comb begin
        arg_3_s_axi_araddr  = addr_q;
        arg_3_s_axi_arlen   = len_q;
        arg_3_s_axi_arburst = 2'd1;
        arg_3_s_axi_arsize  = ARSIZE_VAL;
        arg_3_s_axi_arvalid = arvalid_q;
        arg_3_s_axi_rready  = in_data & arg_0_write_ready;
        arg_0_write_valid   = beat;
        arg_0_in_data       = in_data ? arg_3_s_axi_rdata : 32'd0;
        arg_0_read_valid    = 1'b0;
        valid               = valid_q;

        arg_3_s_axi_awaddr  = 16'd0;
        arg_3_s_axi_awburst = 2'd0;
        arg_3_s_axi_awlen   = 8'd0;
        arg_3_s_axi_awsize  = 3'd0;
        arg_3_s_axi_awvalid = 1'b0;
        arg_3_s_axi_wdata   = 32'd0;
        arg_3_s_axi_wstrb   = 4'd0;
        arg_3_s_axi_wvalid  = 1'b0;
        arg_3_s_axi_bready  = 1'b0;

        arg_1_raddr = 8'd0;
        arg_1_waddr = 8'd0;
        arg_1_wdata = 8'd0;
        arg_1_wen   = 1'b0;
        arg_2_raddr = 16'd0;
        arg_2_waddr = 16'd0;
        arg_2_wdata = 16'd0;
        arg_2_wen   = 1'b0;
    end

    // Inputs that exist only for interface completeness
    assign unused_inputs = ^{arg_0_out_data, arg_0_read_ready, arg_3_s_axi_awready,
                             arg_3_s_axi_wready, arg_3_s_axi_bvalid};

endmodule

// File: tb/tb_axi_rb.sv
module tb_axi_rb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data;
    logic        write_valid;
    logic        write_ready = 1'b0;
    logic        read_valid;
    logic [31:0] out_data = 32'd0;
    logic        read_ready = 1'b0;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [15:0] awaddr;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [7:0]  a1_raddr, a1_waddr, a1_wdata;
    logic        a1_wen;
    logic [7:0]  a1_rdata = 8'd0;
    logic [15:0] a2_raddr, a2_waddr, a2_wdata;
    logic        a2_wen;
    logic [15:0] a2_rdata = 16'd0;
    logic        valid;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    axi_rb #(.ARSIZE_VAL(3'd2)) dut (
        .clk(clk), .rst(rst),
        .arg_0_in_data(in_data), .arg_0_write_valid(write_valid),
        .arg_0_write_ready(write_ready), .arg_0_read_valid(read_valid),
        .arg_0_out_data(out_data), .arg_0_read_ready(read_ready),
        .arg_3_s_axi_araddr(araddr), .arg_3_s_axi_arlen(arlen),
        .arg_3_s_axi_arburst(arburst), .arg_3_s_axi_arsize(arsize),
        .arg_3_s_axi_arvalid(arvalid), .arg_3_s_axi_arready(arready),
        .arg_3_s_axi_rdata(rdata), .arg_3_s_axi_rvalid(rvalid),
        .arg_3_s_axi_rready(rready),
        .arg_3_s_axi_awaddr(awaddr), .arg_3_s_axi_awburst(awburst),
        .arg_3_s_axi_awlen(awlen), .arg_3_s_axi_awsize(awsize),
        .arg_3_s_axi_awvalid(awvalid), .arg_3_s_axi_awready(1'b0),
        .arg_3_s_axi_wdata(wdata), .arg_3_s_axi_wstrb(wstrb),
        .arg_3_s_axi_wvalid(wvalid), .arg_3_s_axi_wready(1'b0),
        .arg_3_s_axi_bvalid(1'b0), .arg_3_s_axi_bready(bready),
        .arg_1_raddr(a1_raddr), .arg_1_rdata(a1_rdata),
        .arg_1_waddr(a1_waddr), .arg_1_wdata(a1_wdata), .arg_1_wen(a1_wen),
        .arg_2_raddr(a2_raddr), .arg_2_rdata(a2_rdata),
        .arg_2_waddr(a2_waddr), .arg_2_wdata(a2_wdata), .arg_2_wen(a2_wen),
        .valid(valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_tied;
        chk("tied_write_ch", {16'd0, awaddr} | {30'd0, awburst} | {24'd0, awlen} |
            {29'd0, awsize} | {31'd0, awvalid} | wdata | {28'd0, wstrb} |
            {31'd0, wvalid} | {31'd0, bready}, 32'd0);
        chk("tied_regs", {24'd0, a1_raddr | a1_waddr | a1_wdata} |
            {16'd0, a2_raddr | a2_waddr | a2_wdata} | {30'd0, a1_wen, a2_wen} |
            {31'd0, read_valid}, 32'd0);
        chk("arburst", {30'd0, arburst}, 32'd1);
        chk("arsize", {29'd0, arsize}, 32'd2);
    endtask

    // Everything except the constants must read 0 while reset is held
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
        chk({tag, "_rready"}, {31'd0, rready}, 32'd0);
        chk({tag, "_wvalid"}, {31'd0, write_valid}, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_araddr"}, {16'd0, araddr}, 32'd0);
        chk({tag, "_arlen"}, {24'd0, arlen}, 32'd0);
        chk({tag, "_in_data"}, in_data, 32'd0);
        chk_tied();
    endtask

    typedef struct {
        int len;
        int addr;
        int ar_delay;
        int wr_mode;   // 0 always ready, 1 toggle every cycle
        int rv_mode;   // 0 always valid, 1 random
        int abort;     // beats before mid-burst reset, -1 none
    } vec_t;

    task automatic run_burst(input vec_t v);
        int beats;
        int budget;
        logic wr, rv;
        logic [31:0] d;
        logic [31:0] e;
        exp_q.delete();
        // reset with the bus looking busy, outputs must still be zero
        @(negedge clk);
        rvalid = 1'b1; write_ready = 1'b1; arready = 1'b1; rdata = 32'hDEAD_BEEF;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst");
        a1_rdata = v.len[7:0];
        a2_rdata = v.addr[15:0];
        arready  = (v.ar_delay == 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_arvalid", {31'd0, arvalid}, 32'd0);
        chk("idle_rready", {31'd0, rready}, 32'd0);
        // address phase: held stable until arready sampled
        for (int i = 0; i <= v.ar_delay; i++) begin
            @(negedge clk);
            a1_rdata = 8'h5A;
            a2_rdata = 16'hA5A5;
            arready  = (i == v.ar_delay);
            rvalid   = 1'b1;
            write_ready = 1'b1;
            #1;
            chk("addr_arvalid", {31'd0, arvalid}, 32'd1);
            chk("addr_araddr", {16'd0, araddr}, v.addr[15:0]);
            chk("addr_arlen", {24'd0, arlen}, v.len[7:0]);
            chk("addr_rready", {31'd0, rready}, 32'd0);
            chk("addr_wvalid", {31'd0, write_valid}, 32'd0);
        end
        // data phase
        beats  = 0;
        budget = 4 * (v.len + 1) + 20;
        while (beats < v.len + 1) begin
            @(negedge clk);
            if (budget == 0) begin
                n_chk++; n_fail++;
                $display("FAIL data_timeout: got %0d beats, expected %0d", beats, v.len + 1);
                break;
            end
            budget--;
            wr = (v.wr_mode == 0) ? 1'b1 : ((budget % 2) == 0);
            rv = (v.rv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d  = $urandom;
            write_ready = wr; rvalid = rv; rdata = d;
            arready = 1'($urandom_range(0, 1));
            if (beats == v.abort) begin
                rst = 1'b0;
                #1;
                chk_reset_outputs("abort");
                exp_q.delete();
                return;
            end
            #1;
            chk("data_rready", {31'd0, rready}, {31'd0, wr});
            chk("data_arvalid", {31'd0, arvalid}, 32'd0);
            chk("data_valid", {31'd0, valid}, 32'd0);
            if (rv && wr) begin
                exp_q.push_back(d);
                beats++;
            end
            chk("data_wvalid", {31'd0, write_valid}, {31'd0, rv & wr});
            if (write_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL push_unexpected: got 0x%0h, expected no push", in_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("push_data", in_data, e);
                end
            end
        end
        chk("pushes_left", exp_q.size(), 32'd0);
        // done: terminal, ignores further bus activity
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rvalid = 1'b1; write_ready = 1'b1; arready = 1'b1;
            #1;
            chk("done_valid", {31'd0, valid}, 32'd1);
            chk("done_rready", {31'd0, rready}, 32'd0);
            chk("done_wvalid", {31'd0, write_valid}, 32'd0);
            chk("done_arvalid", {31'd0, arvalid}, 32'd0);
        end
        chk_tied();
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{len: 3,   addr: 'h1000, ar_delay: 0, wr_mode: 0, rv_mode: 0, abort: -1};
        vecs[1] = '{len: 3,   addr: 'h2345, ar_delay: 5, wr_mode: 0, rv_mode: 0, abort: -1};
        vecs[2] = '{len: 0,   addr: 'hABCD, ar_delay: 0, wr_mode: 0, rv_mode: 0, abort: -1};
        vecs[3] = '{len: 255, addr: 'h0040, ar_delay: 1, wr_mode: 0, rv_mode: 1, abort: -1};
        vecs[4] = '{len: 3,   addr: 'h5555, ar_delay: 0, wr_mode: 1, rv_mode: 0, abort: -1};
        vecs[5] = '{len: 3,   addr: 'h7777, ar_delay: 0, wr_mode: 0, rv_mode: 0, abort: 2};
        vecs[6] = '{len: 7,   addr: 'h0100, ar_delay: 2, wr_mode: 1, rv_mode: 1, abort: -1};

        #2;
        chk_reset_outputs("por");
        for (int k = 0; k < 7; k++) begin
            run_burst(vecs[k]);
        end

        // hand sequence: arready pulsing while in IDLE must not skip the address phase
        @(negedge clk);
        rst = 1'b0; arready = 1'b1;
        a1_rdata = 8'd1; a2_rdata = 16'hC0DE;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("seq_addr_arvalid", {31'd0, arvalid}, 32'd1);
        chk("seq_addr_araddr", {16'd0, araddr}, 32'h0000_C0DE);
        @(negedge clk);
        #1;
        chk("seq_data_entered", {31'd0, rready}, 32'd1);
        chk("seq_data_arvalid", {31'd0, arvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
